// File: rtl/xaddrgen_seq.sv
// ============================================================================
// Module   : xaddrgen_seq
// Purpose  : Job sequencer queueing config bundles for the address generator.
//            Optional replay of completed bundles: XADDRGEN_SEQ_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xaddrgen_seq #(
    parameter int unsigned CFG_W   = 128,
    parameter int unsigned DEPTH_W = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
`ifdef XADDRGEN_SEQ_LOOP_EN
    input  logic               loop_i,
`endif
    input  logic               abort_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [CFG_W-1:0]   in_cfg_i,
    output logic [CFG_W-1:0]   cfg_o,
    output logic               run_o,
    input  logic               done_i,
    output logic               busy_o,
    output logic               job_done_o,
    output logic [DEPTH_W:0]   count_o,
    output logic [CNT_W-1:0]   jobs_o
);

    localparam int unsigned C_DEPTH = 1 << DEPTH_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ARM   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [CFG_W-1:0]   r_mem [C_DEPTH];
    logic [DEPTH_W:0]   r_wr_ptr;
    logic [DEPTH_W:0]   r_rd_ptr;
    logic [CFG_W-1:0]   r_cfg;
    logic [CNT_W-1:0]   r_jobs;

    logic [DEPTH_W:0]   w_count;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_host_push;
    logic               w_repush;
    logic               w_complete;
    logic [CFG_W-1:0]   w_push_data;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == (DEPTH_W+1)'(C_DEPTH));
    assign w_complete  = (r_state == WAIT) && done_i && !abort_i;
    assign w_pop       = (r_state == IDLE) && enable_i && (w_count != '0) && !abort_i;

`ifdef XADDRGEN_SEQ_LOOP_EN
    // Replay write-back claims the tail slot ahead of the host; a full queue drops it.
    assign w_repush    = w_complete && loop_i && !w_full;
`else
    assign w_repush    = 1'b0;
`endif

    assign in_ready_o  = !w_full && !abort_i && !w_repush;
    assign w_host_push = in_valid_i && in_ready_o;
    assign w_push      = w_repush || w_host_push;
    assign w_push_data = w_repush ? r_cfg : in_cfg_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_W-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (abort_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (DEPTH_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (DEPTH_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cfg <= '0;
        end else if (w_pop) begin
            r_cfg <= r_mem[r_rd_ptr[DEPTH_W-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_jobs <= '0;
        end else if (w_complete) begin
            r_jobs <= r_jobs + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        run_o        = 1'b0;
        job_done_o   = 1'b0;
        if (abort_i) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        w_next_state = ISSUE;
                    end
                end
                ISSUE: begin
                    run_o        = 1'b1;
                    w_next_state = ARM;
                end
                // Generator done still reflects its pre-run idle level here.
                ARM: begin
                    w_next_state = WAIT;
                end
                WAIT: begin
                    if (done_i) begin
                        job_done_o   = 1'b1;
                        w_next_state = IDLE;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    assign cfg_o   = r_cfg;
    assign busy_o  = (r_state != IDLE);
    assign count_o = w_count;
    assign jobs_o  = r_jobs;

endmodule

`default_nettype wire

// File: tb/tb_xaddrgen_seq.sv
// ============================================================================
// Module   : tb_xaddrgen_seq
// Purpose  : Directed self-checking bench for xaddrgen_seq (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xaddrgen_seq;

    localparam int unsigned CFG_W   = 128;
    localparam int unsigned DEPTH_W = 2;
    localparam int unsigned CNT_W   = 16;

    logic               clk;
    logic               rst_n;
    logic               enable;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [CFG_W-1:0]   in_cfg;
    logic [CFG_W-1:0]   cfg;
    logic               run;
    logic               done;
    logic               busy;
    logic               job_done;
    logic [DEPTH_W:0]   count;
    logic [CNT_W-1:0]   jobs;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int r0;
    bit ok;
    logic [CFG_W-1:0] bq [5];

    xaddrgen_seq #(
        .CFG_W   (CFG_W),
        .DEPTH_W (DEPTH_W),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .enable_i   (enable),
        .abort_i    (abort),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_cfg_i   (in_cfg),
        .cfg_o      (cfg),
        .run_o      (run),
        .done_i     (done),
        .busy_o     (busy),
        .job_done_o (job_done),
        .count_o    (count),
        .jobs_o     (jobs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [CFG_W-1:0] obs, input logic [CFG_W-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks follow 1 unit later.
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_run(output bit found);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            next();
            #1;
            if (run === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_cfg = '0; done = 1'b1;
        bq[0] = 128'h1111; bq[1] = 128'h2222; bq[2] = 128'h3333;
        bq[3] = 128'h4444; bq[4] = 128'h5555;

        // Reset values
        next(); next(); #1;
        chk("rst_count", count, 0);
        chk("rst_cfg", cfg, 0);
        chk("rst_run", run, 0);
        chk("rst_busy", busy, 0);
        chk("rst_jobdone", job_done, 0);
        chk("rst_jobs", jobs, 0);
        next(); rst_n = 1'b1; #1;
        chk("rst_ready", in_ready, 1);

        // Single job, 2-cycle push-to-run latency
        next(); in_valid = 1'b1; in_cfg = 128'h1234; enable = 1'b1; #1;
        chk("t1_ready", in_ready, 1);
        next(); in_valid = 1'b0; #1;
        chk("t1_count1", count, 1);
        chk("t1_run_early", run, 0);
        next(); #1;
        chk("t1_cfg", cfg, 128'h1234);
        chk("t1_run", run, 1);
        chk("t1_busy", busy, 1);
        next(); done = 1'b0; #1;
        chk("t1_run_once", run, 0);
        for (int i = 0; i < 10; i++) begin
            next(); #1;
            chk("t1_wait_nodone", job_done, 0);
        end
        chk("t1_wait_busy", busy, 1);
        next(); done = 1'b1; #1;
        chk("t1_jobdone", job_done, 1);
        next(); #1;
        chk("t1_jobdone_once", job_done, 0);
        chk("t1_jobs", jobs, 1);
        chk("t1_idle", busy, 0);

        // Fill the queue with the sequencer disabled
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next(); in_valid = 1'b1; in_cfg = bq[i]; #1;
            chk("t2_ready_fill", in_ready, 1);
        end
        next(); in_cfg = bq[4]; #1;
        chk("t2_full_ready", in_ready, 0);
        chk("t2_full_count", count, 4);
        next(); in_valid = 1'b0; enable = 1'b1; #1;
        chk("t2_count_hold", count, 4);
        chk("t2_run_none", run, 0);
        for (int j = 0; j < 4; j++) begin
            wait_run(ok);
            chk("t2_run_seen", ok, 1);
            chk("t2_order", cfg, bq[j]);
            next(); done = 1'b0; #1;
            next(); #1;
            chk("t2_no_run_wait", run, 0);
            chk("t2_wait_nodone", job_done, 0);
            next(); done = 1'b1; #1;
            chk("t2_jobdone", job_done, 1);
        end
        next(); #1;
        chk("t2_jobs", jobs, 5);
        chk("t2_empty", count, 0);
        chk("t2_idle", busy, 0);

        // done held high: ARM ignores it; simultaneous push/pop at count 1
        next(); in_valid = 1'b1; in_cfg = 128'hC0; #1;
        next(); in_cfg = 128'hC1; #1;
        chk("t3_pushpop_count_pre", count, 1);
        next(); in_valid = 1'b0; #1;
        chk("t3_pushpop_count", count, 1);
        chk("t3_run0", run, 1);
        chk("t3_cfg0", cfg, 128'hC0);
        r0 = cyc;
        next(); #1;
        chk("t3_arm_ignore", job_done, 0);
        next(); #1;
        chk("t3_wait_first", job_done, 1);
        wait_run(ok);
        chk("t3_run_seen", ok, 1);
        chk("t3_spacing", cyc - r0, 4);
        chk("t3_cfg1", cfg, 128'hC1);
        next(); next(); next(); #1;
        chk("t3_jobs", jobs, 7);

        // Abort in WAIT with two bundles queued
        next(); in_valid = 1'b1; in_cfg = 128'hD0; #1;
        next(); in_cfg = 128'hD1; #1;
        next(); in_cfg = 128'hD2; #1;
        chk("t4_issue", run, 1);
        next(); in_valid = 1'b0; done = 1'b0; #1;
        chk("t4_count2", count, 2);
        next(); abort = 1'b1; done = 1'b1; in_valid = 1'b1; in_cfg = 128'hD3; #1;
        chk("t4_ready_abort", in_ready, 0);
        chk("t4_no_jobdone", job_done, 0);
        chk("t4_busy_wait", busy, 1);
        next(); abort = 1'b0; in_valid = 1'b0; #1;
        chk("t4_flushed", count, 0);
        chk("t4_idle", busy, 0);
        chk("t4_jobs", jobs, 7);
        chk("t4_cfg_kept", cfg, 128'hD0);
        next(); #1;
        chk("t4_no_run", run, 0);

        // Asynchronous reset mid-WAIT
        next(); in_valid = 1'b1; in_cfg = 128'hE0; #1;
        next(); in_valid = 1'b0; #1;
        next(); #1;
        chk("t5_run", run, 1);
        next(); done = 1'b0; #1;
        next(); #1;
        chk("t5_busy_wait", busy, 1);
        rst_n = 1'b0; #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cfg", cfg, 0);
        chk("t5_rst_jobs", jobs, 0);
        chk("t5_rst_count", count, 0);
        chk("t5_rst_run", run, 0);
        next(); rst_n = 1'b1; done = 1'b1; #1;
        chk("t5_ready", in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
